alu_pipe: RTL

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe -- single-issue ALU with a registered result stage and an optional
// iterative shift-add multiplier.
//
// Configuration macro: ALU_PIPE_MUL_EN
//   defined   : op 111 runs the multiplier (BUSY for WIDTH cycles).
//   undefined : op 111 finishes in one cycle, result 0, zero=1, op_err=1.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   in_valid     request present          in_ready   request accepted this cycle
//   a, b         operands (WIDTH)         op         opcode (3)
//   out_valid    result registers hold an unconsumed result
//   out_ready    consumer takes the result
//   result, carry_out, zero, overflow, op_err   registered result and flags
//   o_dbg_state  current FSM state (IDLE=0, BUSY=1, DONE=2)
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; a producer holds valid and its payload steady until that edge, and the
// result side holds result/flags steady while out_valid is high and out_ready
// is low.
// -----------------------------------------------------------------------------
module alu_pipe #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             zero,
   output logic             overflow,
   output logic             op_err,
   output logic [1:0]       o_dbg_state
);

   localparam int SW = $clog2(WIDTH);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic             w_accept;
   logic             w_is_mul;

   logic [WIDTH-1:0] r_result;
   logic             r_carry;
   logic             r_zero;
   logic             r_ovf;
   logic             r_err;

   // single-cycle datapath
   logic [SW-1:0]    w_sh;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_diff;
   logic [WIDTH:0]   w_shl;
   logic [WIDTH:0]   w_shr;
   logic [WIDTH-1:0] w_res;
   logic             w_carry;
   logic             w_ovf;
   logic             w_err;

`ifdef ALU_PIPE_MUL_EN
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [2*WIDTH-1:0] r_acc;
   logic [SW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] w_partial;
   logic               w_mul_last;

   assign w_is_mul   = (op == OP_MUL);
   assign w_partial  = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign w_mul_last = (r_cnt == SW'(WIDTH - 1));
`else
   assign w_is_mul   = 1'b0;
`endif

   assign in_ready    = (r_state == IDLE) || ((r_state == DONE) && out_ready);
   assign w_accept    = in_valid && in_ready;
   assign out_valid   = (r_state == DONE);
   assign o_dbg_state = r_state;

   assign result      = r_result;
   assign carry_out   = r_carry;
   assign zero        = r_zero;
   assign overflow    = r_ovf;
   assign op_err      = r_err;

   always_comb begin
      w_sh    = b[SW-1:0];
      w_sum   = {1'b0, a} + {1'b0, b};
      w_diff  = {1'b0, a} - {1'b0, b};
      // The extra bit on each shifter catches the last bit shifted out.
      w_shl   = {1'b0, a} << w_sh;
      w_shr   = {a, 1'b0} >> w_sh;
      w_res   = '0;
      w_carry = 1'b0;
      w_ovf   = 1'b0;
      w_err   = 1'b0;
      case (op)
         OP_ADD: begin
            w_res   = w_sum[WIDTH-1:0];
            w_carry = w_sum[WIDTH];
            w_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            w_res   = w_diff[WIDTH-1:0];
            w_carry = w_diff[WIDTH];   // borrow out: a < b unsigned
            w_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: w_res = a & b;
         OP_OR:  w_res = a | b;
         OP_XOR: w_res = a ^ b;
         OP_SHL: begin
            w_res   = w_shl[WIDTH-1:0];
            w_carry = w_shl[WIDTH];
         end
         OP_SHR: begin
            w_res   = w_shr[WIDTH:1];
            w_carry = w_shr[0];
         end
         default: begin
`ifdef ALU_PIPE_MUL_EN
            w_err = 1'b0;      // multiply goes through the iterative path
`else
            w_err = 1'b1;      // no multiplier built: flag the op, result 0
`endif
         end
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (w_accept) w_next = w_is_mul ? BUSY : DONE;
         BUSY: begin
`ifdef ALU_PIPE_MUL_EN
            if (w_mul_last) w_next = DONE;
`else
            w_next = IDLE;
`endif
         end
         DONE: begin
            if (out_ready) begin
               if (w_accept) w_next = w_is_mul ? BUSY : DONE;
               else          w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_result <= '0;
         r_carry  <= 1'b0;
         r_zero   <= 1'b0;
         r_ovf    <= 1'b0;
         r_err    <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
`endif
      end else begin
         r_state <= w_next;
         if (w_accept && !w_is_mul) begin
            r_result <= w_res;
            r_carry  <= w_carry;
            r_zero   <= (w_res == '0);
            r_ovf    <= w_ovf;
            r_err    <= w_err;
         end
`ifdef ALU_PIPE_MUL_EN
         if (w_accept && w_is_mul) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
         end else if (r_state == BUSY) begin
            // One multiplier bit per cycle; the last step writes the product.
            r_acc    <= w_partial;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (w_mul_last) begin
               r_result <= w_partial[WIDTH-1:0];
               r_carry  <= |w_partial[2*WIDTH-1:WIDTH];
               r_zero   <= (w_partial[WIDTH-1:0] == '0);
               r_ovf    <= 1'b0;
               r_err    <= 1'b0;
            end
         end
`endif
      end
   end

endmodule
